// File: rtl/muldiv_seq.sv
// Sequencer for the iterative multiplier/divider: start pulse, PC stall, single writeback, div-by-zero and timeout handling.
// Optional HI register and hi_data port are built only when MULDIV_HI_EN is defined.
module muldiv_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_mul,
  input  logic        inst_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [4:0]  dest,
  output logic        mult_begin,
  input  logic        mult_end,
  input  logic [63:0] product,
  output logic        div_begin,
  input  logic        div_end,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        div_zero,
  output logic        timeout_err
`ifdef MULDIV_HI_EN
  ,
  output logic [31:0] hi_data
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    WB       = 2'd3
  } state_t;

  // The counter is loaded with 1 in the issue cycle so it counts cycles since the begin pulse.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [4:0]        dest_q, dest_nxt;
  logic [31:0]       result, result_nxt;
  logic              dz_q, dz_nxt;
  logic              to_q, to_nxt;
`ifdef MULDIV_HI_EN
  logic [31:0]       hi_q, hi_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= {CNT_W{1'b0}};
      dest_q <= 5'd0;
      result <= 32'd0;
      dz_q   <= 1'b0;
      to_q   <= 1'b0;
`ifdef MULDIV_HI_EN
      hi_q   <= 32'd0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dest_q <= dest_nxt;
      result <= result_nxt;
      dz_q   <= dz_nxt;
      to_q   <= to_nxt;
`ifdef MULDIV_HI_EN
      hi_q   <= hi_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dest_nxt   = dest_q;
    result_nxt = result;
    dz_nxt     = 1'b0;
    to_nxt     = 1'b0;
    mult_begin = 1'b0;
    div_begin  = 1'b0;
`ifdef MULDIV_HI_EN
    hi_nxt     = hi_q;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = {CNT_W{1'b0}};
        if (inst_mul) begin
          mult_begin = 1'b1;
          dest_nxt   = dest;
          cnt_nxt    = CNT_ONE;
          state_nxt  = MUL_WAIT;
        end else if (inst_div) begin
          dest_nxt = dest;
          if (op2 != 32'd0) begin
            div_begin = 1'b1;
            cnt_nxt   = CNT_ONE;
            state_nxt = DIV_WAIT;
          end else begin
            result_nxt = 32'hFFFF_FFFF;
            dz_nxt     = 1'b1;
`ifdef MULDIV_HI_EN
            hi_nxt     = op1;
`endif
            state_nxt  = WB;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        if ((state == MUL_WAIT) && mult_end) begin
          result_nxt = product[31:0];
`ifdef MULDIV_HI_EN
          hi_nxt     = product[63:32];
`endif
          cnt_nxt    = {CNT_W{1'b0}};
          state_nxt  = WB;
        end else if ((state == DIV_WAIT) && div_end) begin
          result_nxt = quotient;
`ifdef MULDIV_HI_EN
          hi_nxt     = remainder;
`endif
          cnt_nxt    = {CNT_W{1'b0}};
          state_nxt  = WB;
        end else if (cnt >= CNT_LAST) begin
          result_nxt = 32'd0;
          to_nxt     = 1'b1;
`ifdef MULDIV_HI_EN
          hi_nxt     = 32'd0;
`endif
          cnt_nxt    = {CNT_W{1'b0}};
          state_nxt  = WB;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WB: begin
        // The same instruction is still presented here, so decode is ignored.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign stall       = ((state == IDLE) && (inst_mul || inst_div)) ||
                       (state == MUL_WAIT) || (state == DIV_WAIT);
  assign busy        = (state != IDLE);
  assign wb_en       = (state == WB);
  assign wb_addr     = (state == WB) ? dest_q : 5'd0;
  assign wb_data     = (state == WB) ? result : 32'd0;
  assign div_zero    = (state == WB) && dz_q;
  assign timeout_err = (state == WB) && to_q;
`ifdef MULDIV_HI_EN
  assign hi_data     = hi_q;
`endif

  // product[63:32] and remainder only feed the HI register.
  logic unused_hi;
  assign unused_hi = ^{product[63:32], remainder};

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq; the bench also plays the multiplier/divider units.
module tb_muldiv_seq;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_mul, inst_div;
  logic [31:0] op1, op2;
  logic [4:0]  dest;
  logic        mult_begin, mult_end, div_begin, div_end;
  logic [63:0] product;
  logic [31:0] quotient, remainder;
  logic        stall, wb_en, busy, div_zero, timeout_err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`ifdef MULDIV_HI_EN
  logic [31:0] hi_data;
`endif

  int vectors = 0;
  int errors  = 0;

  muldiv_seq #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .inst_mul(inst_mul), .inst_div(inst_div),
    .op1(op1), .op2(op2), .dest(dest),
    .mult_begin(mult_begin), .mult_end(mult_end), .product(product),
    .div_begin(div_begin), .div_end(div_end), .quotient(quotient), .remainder(remainder),
    .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .div_zero(div_zero), .timeout_err(timeout_err)
`ifdef MULDIV_HI_EN
    , .hi_data(hi_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One MUL/DIV instruction; k = cycles from begin to *_end, k < 0 means the unit never answers.
  // hold keeps the decode asserted so the next call sees it back-to-back.
  task automatic run_op(input bit is_mul, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input int k, input bit hold);
    int cyc = 0, bcyc = -1, nstall = 0, nmb = 0, ndb = 0, nflag = 0;
    bit got_wb = 1'b0;
    logic [31:0] wdata = 32'd0, whi = 32'd0;
    logic [4:0]  waddr = 5'd0;
    logic        wdz = 1'b0, wto = 1'b0;
    logic [63:0] prod = {32'd0, a} * {32'd0, b};
    bit use_mul = is_mul;
    bit zero_div = !is_mul && (b == 32'd0);
    int exp_stall;
    logic [31:0] exp_data, exp_hi;
    inst_mul = is_mul; inst_div = is_div; op1 = a; op2 = b; dest = d;
    while (!got_wb && cyc < 200) begin
      mult_end = 1'b0; div_end = 1'b0;
      product = {$urandom, $urandom}; quotient = $urandom; remainder = $urandom;
      if (bcyc >= 0 && k >= 0 && cyc == bcyc + k) begin
        if (use_mul) begin mult_end = 1'b1; product = prod; end
        else begin div_end = 1'b1; quotient = a / b; remainder = a % b; end
      end else if (bcyc >= 0 && cyc == bcyc + 1) begin
        // stray done pulse from the other unit
        if (use_mul) div_end = 1'b1; else mult_end = 1'b1;
      end
      @(negedge clk);
      if (mult_begin) begin nmb++; if (bcyc < 0) bcyc = cyc; end
      if (div_begin)  begin ndb++; if (bcyc < 0) bcyc = cyc; end
      if (div_zero || timeout_err) nflag++;
      if (wb_en) begin
        got_wb = 1'b1; waddr = wb_addr; wdata = wb_data; wdz = div_zero; wto = timeout_err;
`ifdef MULDIV_HI_EN
        whi = hi_data;
`endif
        check("stall_in_wb", stall, 0);
        check("busy_in_wb", busy, 1);
      end else if (stall) nstall++;
      @(posedge clk); #1;
      cyc++;
    end
    if (zero_div) begin
      exp_stall = 1; exp_data = 32'hFFFF_FFFF; exp_hi = a;
    end else if (k < 0) begin
      exp_stall = TIMEOUT; exp_data = 32'd0; exp_hi = 32'd0;
    end else begin
      exp_stall = k + 1;
      exp_data = use_mul ? prod[31:0] : a / b;
      exp_hi   = use_mul ? prod[63:32] : a % b;
    end
    check("wb_seen", got_wb, 1);
    check("mult_begins", nmb, use_mul ? 1 : 0);
    check("div_begins", ndb, (!use_mul && !zero_div) ? 1 : 0);
    if (!zero_div) check("begin_cycle", bcyc, 0);
    check("stall_cycles", nstall, exp_stall);
    check("wb_addr", waddr, d);
    check("wb_data", wdata, exp_data);
    check("div_zero", wdz, zero_div);
    check("timeout_err", wto, (k < 0 && !zero_div) ? 1 : 0);
    check("flag_cycles", nflag, (zero_div || k < 0) ? 1 : 0);
`ifdef MULDIV_HI_EN
    check("hi_data", whi, exp_hi);
`else
    check("hi_unused", whi | exp_hi[0 +: 1] & 1'b0, 0);
`endif
    if (!hold) begin
      inst_mul = 1'b0; inst_div = 1'b0; mult_end = 1'b0; div_end = 1'b0;
      @(negedge clk);
      check("idle_after_wb", {wb_en, stall, busy, div_zero, timeout_err}, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit saw_wb;
    reset = 1'b1; inst_mul = 1'b0; inst_div = 1'b0; op1 = 32'd0; op2 = 32'd0; dest = 5'd0;
    mult_end = 1'b0; div_end = 1'b0; product = 64'd0; quotient = 32'd0; remainder = 32'd0;
    #1;
    check("reset_outputs", {mult_begin, div_begin, stall, wb_en, wb_addr, wb_data, busy, div_zero, timeout_err}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // done pulses while idle must not write
    mult_end = 1'b1; div_end = 1'b1;
    @(negedge clk);
    check("idle_end_ignored", {wb_en, stall, busy}, 0);
    @(posedge clk); #1 mult_end = 1'b0; div_end = 1'b0;
    @(negedge clk);
    check("idle_end_ignored2", {wb_en, stall, busy}, 0);
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd9, 32, 1'b0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd3, 33, 1'b0);
    run_op(1'b0, 1'b1, 32'd55, 32'd0, 5'd5, 1, 1'b0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd12, -1, 1'b0);
    run_op(1'b0, 1'b1, 32'd9, 32'd2, 5'd13, -1, 1'b0);
    run_op(1'b1, 1'b1, 32'd11, 32'd0, 5'd1, 5, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, 1'b1);
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 63, 1'b0);

    // reset ten cycles into MUL_WAIT, then a late done pulse
    inst_mul = 1'b1; op1 = 32'd5; op2 = 32'd5; dest = 5'd7;
    repeat (11) @(posedge clk);
    #2 reset = 1'b1; inst_mul = 1'b0;
    #1;
    check("reset_mid_op", {mult_begin, stall, wb_en, wb_addr, wb_data, busy}, 0);
    @(posedge clk); #1 reset = 1'b0;
    saw_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mult_end = (i == 1); product = 64'd25;
      @(negedge clk);
      if (wb_en || busy) saw_wb = 1'b1;
      @(posedge clk); #1;
    end
    mult_end = 1'b0;
    check("no_wb_after_reset", saw_wb, 0);

    for (int n = 0; n < 24; n++) begin
      bit m = $urandom_range(0, 1);
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (n % 3 == 0) b = b >> $urandom_range(0, 31);
      run_op(m, !m, a, b, 5'($urandom_range(0, 31)), $urandom_range(1, 40), 1'(n % 4 == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for the iterative multiplier and divider in the single-cycle CPU.
- Detects MUL/DIV decode, issues a one-cycle start pulse to the selected unit, and stalls PC update until the unit reports done.
- Captures the result and issues exactly one register-file write pulse per instruction.
- Handles divide-by-zero and a hung unit (timeout) so the core can never lock up.

Parameters:
- TIMEOUT, 64, max cycles waited for mult_end/div_end before forced completion.
- CNT_W, 7, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- inst_mul  in  1  decoded MUL, level for whole instruction
- inst_div  in  1  decoded DIV, level for whole instruction
- op1  in  32  source operand 1 (rs value)
- op2  in  32  source operand 2 (rt value)
- dest  in  5  destination register number
- mult_begin  out  1  one-cycle start pulse to multiplier
- mult_end  in  1  multiplier done pulse
- product  in  64  multiplier result, valid with mult_end
- div_begin  out  1  one-cycle start pulse to divider
- div_end  in  1  divider done pulse
- quotient  in  32  divider quotient, valid with div_end
- remainder  in  32  divider remainder, valid with div_end
- stall  out  1  hold PC and suppress other writebacks
- wb_en  out  1  register-file write enable for the result
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- busy  out  1  state != IDLE
- div_zero  out  1  one-cycle flag: DIV with op2 == 0
- timeout_err  out  1  one-cycle flag: unit did not finish in time
- hi_data  out  32  present only with MULDIV_HI_EN (see Optional Feature)

Behaviour:
- Reset (async, reset=1): state=IDLE, counter=0, op/dest latches=0, all outputs 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, WB.
- IDLE:
  - inst_mul=1 -> mult_begin=1 this cycle; latch dest; next MUL_WAIT.
  - else inst_div=1 and op2!=0 -> div_begin=1; latch dest; next DIV_WAIT.
  - inst_div=1 and op2==0 -> no div_begin; result=32'hFFFFFFFF; div_zero=1 in WB cycle; next WB.
  - inst_mul and inst_div both 1 -> MUL has priority, DIV ignored.
- MUL_WAIT / DIV_WAIT:
  - Counter increments each cycle.
  - Matching *_end=1 -> capture product[31:0] or quotient into result register; next WB.
  - Counter == TIMEOUT-1 without end -> result=0; timeout_err=1 in WB cycle; next WB.
  - The non-matching *_end is ignored. Counter clears on leaving the WAIT state.
- WB: wb_en=1, wb_addr=latched dest, wb_data=result, stall=0, for exactly one cycle; next IDLE unconditionally. inst_mul/inst_div are ignored in WB, because the same instruction is still presented.
- stall (combinational) = (IDLE & (inst_mul|inst_div)) | MUL_WAIT | DIV_WAIT.
- begin pulses, wb_en, div_zero and timeout_err are each high for one cycle only.
- Latency: if the unit asserts *_end k cycles after *_begin (k>=1), stall is high k+1 cycles, WB follows, and the instruction occupies k+2 cycles. A DIV with op2==0 occupies 2 cycles.
- Back-to-back MUL/DIV: the next instruction is seen in IDLE the cycle after WB; no bubble beyond that.
- *_end seen in IDLE or WB: ignored, no write.
- Reset mid-operation: immediate return to IDLE; no wb_en; a pending unit done pulse after reset is ignored.
- Operands are passed through (op1/op2 are driven stable by the core while stalled); only dest and result are registered.

Optional Feature:
- Macro: MULDIV_HI_EN.
- Defined: adds 32-bit HI register and output hi_data.
  - Loaded with product[63:32] on mult_end, or remainder on div_end.
  - Loaded with op1 on divide-by-zero.
  - Loaded with 0 on timeout.
  - Reset 0; holds value otherwise.
- Undefined: no HI register, no hi_data port; product[63:32] and remainder are unused.

Test Plan:
- MUL op1=7, op2=6, dest=9, model asserts mult_end 32 cycles after begin, product=42 -> mult_begin 1 cycle, stall 33 cycles, then wb_en=1, wb_addr=9, wb_data=42 for 1 cycle.
- DIV op1=100, op2=7, dest=3, div_end after 33 cycles -> wb_data=14; hi_data=2 with MULDIV_HI_EN.
- DIV op2=0, dest=5 -> no div_begin, stall 1 cycle, next cycle wb_data=FFFFFFFF, div_zero=1.
- MUL with mult_end never asserted, TIMEOUT=64 -> stall 64 cycles, then wb_en=1, wb_data=0, timeout_err=1, then IDLE.
- reset asserted 10 cycles into MUL_WAIT, then mult_end pulses later -> outputs 0 immediately, no wb_en ever.
- inst_mul=inst_div=1 together; then back-to-back MUL, MUL -> only mult_begin fires; second mult_begin exactly 1 cycle after first WB.
